// File: rtl/rsa_core_arbiter.sv
// Round-robin arbiter sharing one RSA exponentiation core between requesters.
// Optional WAIT watchdog enabled by defining RSA_ARB_TIMEOUT_EN.
module rsa_core_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 512,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*DATA_W-1:0] i_a,
    input  logic [NUM_REQ*DATA_W-1:0] i_e,
    input  logic [NUM_REQ*DATA_W-1:0] i_n,
    input  logic [NUM_REQ-1:0]        i_key_size,
    output logic [NUM_REQ-1:0]        o_ack,
    output logic [NUM_REQ-1:0]        o_valid,
    output logic [DATA_W-1:0]         o_result,
    output logic                      o_err,
    output logic                      o_busy,
    output logic                      o_core_start,
    output logic [DATA_W-1:0]         o_core_a,
    output logic [DATA_W-1:0]         o_core_e,
    output logic [DATA_W-1:0]         o_core_n,
    output logic                      o_core_key_size,
    output logic                      o_core_rst,
    input  logic [DATA_W-1:0]         i_core_result,
    input  logic                      i_core_finished
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if ((NUM_REQ < 2) || (NUM_REQ > 8) || (TIMEOUT_CYC < 2)) begin : g_bad_param
        $error("rsa_core_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t state, state_nx;
    logic [GW-1:0] g, rr_ptr, pick, idx;
    logic found, tmo, abort;
    logic [NUM_REQ-1:0] g_oh;

    // First requesting index at or above rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = GW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && i_req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (found) state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (i_core_finished || tmo) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            g               <= '0;
            rr_ptr          <= '0;
            o_result        <= '0;
            o_core_a        <= '0;
            o_core_e        <= '0;
            o_core_n        <= '0;
            o_core_key_size <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (found) begin
                    g               <= pick;
                    o_core_a        <= i_a[pick*DATA_W +: DATA_W];
                    o_core_e        <= i_e[pick*DATA_W +: DATA_W];
                    o_core_n        <= i_n[pick*DATA_W +: DATA_W];
                    o_core_key_size <= i_key_size[pick];
                end
                WAIT: begin
                    if (i_core_finished) o_result <= i_core_result;
                    else if (tmo)        o_result <= '0;
                end
                DONE: rr_ptr <= (g == GW'(NUM_REQ-1)) ? '0 : g + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef RSA_ARB_TIMEOUT_EN
    logic [20:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt   <= '0;
            abort <= 1'b0;
        end else begin
            if (state == START)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 21'd1;
            // A finish pulse coinciding with the limit takes precedence.
            abort <= (state == WAIT) && tmo && !i_core_finished;
        end
    end

    assign tmo = (state == WAIT) && (cnt == 21'(TIMEOUT_CYC-1));
`else
    assign tmo   = 1'b0;
    assign abort = 1'b0;
`endif

    assign g_oh         = NUM_REQ'(1) << g;
    assign o_busy       = (state != IDLE) && !i_rst;
    assign o_core_start = (state == START) && !i_rst;
    assign o_ack        = o_core_start ? g_oh : '0;
    assign o_valid      = ((state == DONE) && !i_rst) ? g_oh : '0;
    assign o_err        = (state == DONE) && abort && !i_rst;
    assign o_core_rst   = i_rst || o_err;

endmodule
